// File: rtl/clk_div_pkg.sv
// Shared types and reset defaults for the multi-channel clock/strobe divider.
package clk_div_pkg;

  // Width of the period and high-time fields. clk_div_multi's WIDTH must match this.
  localparam int CFG_WIDTH = 16;

  // Reset defaults: the legacy fixed 50-cycle, 25-high, low-first divider.
  localparam int DEF_DIV  = 50;
  localparam int DEF_HIGH = 25;
  localparam int DEF_INV  = 1;
  localparam int DEF_EN   = 1;

  // One channel's configuration. inv = 1 means the output is low while cnt < high.
  typedef struct packed {
    logic [CFG_WIDTH-1:0] div;
    logic [CFG_WIDTH-1:0] high;
    logic                 inv;
    logic                 en;
  } chan_cfg_t;

  // Build a configuration record from plain integers (used for parameter defaults).
  function automatic chan_cfg_t make_cfg(int div, int high, int inv, int en);
    chan_cfg_t c;
    c.div  = CFG_WIDTH'(div);
    c.high = CFG_WIDTH'(high);
    c.inv  = 1'(inv);
    c.en   = 1'(en);
    return c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow config, boundary-aligned apply and
// registered clk_out/tick/pending. Outputs are registered from next-state values
// so they stay cycle-aligned with the counter.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter chan_cfg_t DEF_CFG = make_cfg(DEF_DIV, DEF_HIGH, DEF_INV, DEF_EN)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      we_i,
  input  chan_cfg_t wr_cfg_i,
  input  logic      sync_i,
  output logic      clk_out_o,
  output logic      tick_o,
  output logic      pending_o
);

  // Output level implied by the reset config with cnt = 0.
  localparam logic RST_CLK = DEF_CFG.en ? ((DEF_CFG.high != '0) ^ DEF_CFG.inv) : DEF_CFG.inv;

  chan_cfg_t            act_q, act_d;
  chan_cfg_t            shd_q, shd_d;
  logic [CFG_WIDTH-1:0] cnt_q, cnt_d;
  logic [CFG_WIDTH-1:0] last_cnt;
  logic                 pend_q, pend_d;
  logic                 clk_out_q, clk_out_d;
  logic                 tick_q, tick_d;
  logic                 boundary;
  logic                 apply;

  // Next-state: count, decide the apply point, and derive the registered outputs.
  // A disabled channel applies immediately; a running one only after cnt == P-1
  // or on sync, so no period is ever cut short. A write coinciding with an apply
  // point goes straight to the active config.
  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;

    last_cnt = (act_q.div == '0) ? '0 : act_q.div - 1'b1;
    boundary = act_q.en && (cnt_q == last_cnt);
    apply    = boundary || sync_i || !act_q.en;

    if (we_i) begin
      shd_d = wr_cfg_i;
    end

    if (apply) begin
      if (we_i) begin
        act_d = wr_cfg_i;
      end else if (pend_q) begin
        act_d = shd_q;
      end
      pend_d = 1'b0;
      cnt_d  = '0;
    end else begin
      // Enabled and strictly below P-1 here, so the increment cannot pass P-1.
      if (we_i) begin
        pend_d = 1'b1;
      end
      cnt_d = cnt_q + 1'b1;
    end

    clk_out_d = act_d.en ? ((cnt_d < act_d.high) ^ act_d.inv) : act_d.inv;
    tick_d    = act_d.en && (cnt_d == '0);
  end

  // State and output registers; reset restores the legacy divider behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= DEF_CFG;
      shd_q     <= DEF_CFG;
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      clk_out_q <= RST_CLK;
      tick_q    <= DEF_CFG.en;
    end else begin
      act_q     <= act_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Programmable multi-channel clock/strobe divider. Decodes the config write bus
// to one channel and fans sync out to all of them.
// Config interface: cfg_we is a single-cycle strobe with no ready; every write is
// accepted in the cycle it is presented. Writes to a cfg_chan with no channel
// behind it are dropped.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = CFG_WIDTH,
  parameter int DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH,
  parameter int DEF_INV  = clk_div_pkg::DEF_INV,
  parameter int DEF_EN   = clk_div_pkg::DEF_EN
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [WIDTH-1:0]                                 cfg_div,
  input  logic [WIDTH-1:0]                                 cfg_high,
  input  logic                                             cfg_inv,
  input  logic                                             cfg_en,
  input  logic                                             sync,
  output logic [CHANNELS-1:0]                              clk_out,
  output logic [CHANNELS-1:0]                              tick,
  output logic [CHANNELS-1:0]                              pending
);

  localparam int        CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam chan_cfg_t RST_CFG = make_cfg(DEF_DIV, DEF_HIGH, DEF_INV, DEF_EN);

  chan_cfg_t           wr_cfg;
  logic [CHANNELS-1:0] chan_we;

  // Bundle the write bus into one record and decode the target channel.
  always_comb begin
    wr_cfg.div  = cfg_div;
    wr_cfg.high = cfg_high;
    wr_cfg.inv  = cfg_inv;
    wr_cfg.en   = cfg_en;
    for (int i = 0; i < CHANNELS; i++) begin
      chan_we[i] = cfg_we && (cfg_chan == CHAN_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .DEF_CFG (RST_CFG)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .we_i      (chan_we[g]),
      .wr_cfg_i  (wr_cfg),
      .sync_i    (sync),
      .clk_out_o (clk_out[g]),
      .tick_o    (tick[g]),
      .pending_o (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: reset/default pattern with a running reconfiguration,
// a table of channel configurations applied through the disabled path, sync
// realignment with a same-cycle write, and asynchronous reset with pending writes.
module tb_clk_div_multi;

  localparam int CH = 4;
  localparam int W  = 3 * CH;  // {clk_out, tick, pending}

  // ---------------- clock / reset ----------------
  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          cfg_we   = 1'b0;
  logic [1:0]    cfg_chan = '0;
  logic [15:0]   cfg_div  = '0;
  logic [15:0]   cfg_high = '0;
  logic          cfg_inv  = 1'b0;
  logic          cfg_en   = 1'b0;
  logic          sync     = 1'b0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  always #5 clk = ~clk;

  clk_div_multi #(
    .CHANNELS (CH),
    .WIDTH    (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_inv  (cfg_inv),
    .cfg_en   (cfg_en),
    .sync     (sync),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    int          ch;
    int          div;
    int          high;
    logic        inv;
    int          per;   // expected period in cycles
    logic [63:0] pat;   // expected clk_out per cycle of a period, bit 0 first
    string       name;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [W-1:0] mk(logic [CH-1:0] c, logic [CH-1:0] t, logic [CH-1:0] p);
    return {c, t, p};
  endfunction

  function automatic logic [W-1:0] ch_mask(int ch);
    logic [CH-1:0] b;
    b     = '0;
    b[ch] = 1'b1;
    return {b, b, b};
  endfunction

  task automatic push(logic [W-1:0] e, logic [W-1:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic check(string name);
    logic [W-1:0] e;
    logic [W-1:0] m;
    logic [W-1:0] got;
    got = {clk_out, tick, pending};
    checks++;
    if (exp_q.size() == 0 || msk_q.size() == 0) begin
      errors++;
      $display("FAIL %s @%0t: no expected entry, got clk/tick/pend %h", name, $time, got);
    end else begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      if ((got & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s @%0t: got clk/tick/pend %h, expected %h (mask %h)",
                 name, $time, got & m, e & m, m);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; inputs driven before the call are sampled at this edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic write_cfg(int ch, int div, int high, logic inv, logic en);
    cfg_we   = 1'b1;
    cfg_chan = 2'(ch);
    cfg_div  = 16'(div);
    cfg_high = 16'(high);
    cfg_inv  = inv;
    cfg_en   = en;
  endtask

  // Default 50/25 low-first pattern on all channels from the first cycle after
  // reset release (observed without an edge). Optionally reconfigure ch1 at cnt=10.
  task automatic run_after_reset(int n, bit wr_ch1);
    for (int k = 0; k < n; k++) begin
      logic [CH-1:0] c;
      logic [CH-1:0] t;
      logic [CH-1:0] p;
      for (int ch = 0; ch < CH; ch++) begin
        c[ch] = (k % 50) >= 25;
        t[ch] = (k % 50) == 0;
        p[ch] = 1'b0;
      end
      if (wr_ch1) begin
        p[1] = (k >= 11) && (k <= 49);
        if (k >= 50) begin
          c[1] = ((k - 50) % 4) == 0;
          t[1] = ((k - 50) % 4) == 0;
        end
      end
      push(mk(c, t, p), '1);
      if (k > 0) cyc();
      check(wr_ch1 ? "dflt_ch1_switch" : "dflt_after_rst");
      if (wr_ch1 && k == 10) write_cfg(1, 4, 1, 1'b0, 1'b1);
    end
  endtask

  // Disable a channel (waits for its boundary) and check it sits at inv.
  task automatic disable_ch(vec_t v);
    int n;
    write_cfg(v.ch, v.div, v.high, v.inv, 1'b0);
    cyc();
    n = 0;
    while (pending[v.ch] && n < 200) begin
      cyc();
      n++;
    end
    begin
      logic [CH-1:0] c;
      c       = '0;
      c[v.ch] = v.inv;
      push(mk(c, '0, '0), ch_mask(v.ch));
      check({v.name, "_disable"});
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{2, 3,  2,  1'b0, 3,  64'h3,                 "ch2_p3_h2"};
    vecs[1] = '{0, 0,  1,  1'b0, 1,  64'h1,                 "ch0_div0"};
    vecs[2] = '{0, 4,  0,  1'b1, 4,  64'hF,                 "ch0_high0"};
    vecs[3] = '{0, 50, 60, 1'b0, 50, 64'h0003_FFFF_FFFF_FFFF, "ch0_high_gt_p"};
    vecs[4] = '{0, 5,  2,  1'b1, 5,  64'h1C,                "ch0_p5_inv"};
    vecs[5] = '{2, 7,  3,  1'b0, 7,  64'h7,                 "ch2_p7_h3"};
    vecs[6] = '{2, 1,  0,  1'b0, 1,  64'h0,                 "ch2_p1_h0"};
    vecs[7] = '{0, 0,  1,  1'b1, 1,  64'h0,                 "ch0_div0_inv"};

    // Reset values while held, then default pattern with a ch1 rewrite mid-period.
    repeat (3) @(posedge clk);
    #1;
    push(mk('0, '1, '0), '1);
    check("reset_hold");
    rst = 1'b0;
    run_after_reset(100, 1'b1);

    // Table: disable, enable with the vector config (applies next cycle),
    // check two full periods, then disable in the first cycle of period three.
    for (int v = 0; v < 8; v++) begin
      int L;
      L = vecs[v].per;
      disable_ch(vecs[v]);
      write_cfg(vecs[v].ch, vecs[v].div, vecs[v].high, vecs[v].inv, 1'b1);
      for (int k = 0; k <= 3 * L; k++) begin
        logic [CH-1:0] c;
        logic [CH-1:0] t;
        logic [CH-1:0] p;
        c = '0;
        t = '0;
        p = '0;
        if (k == 3 * L) begin
          c[vecs[v].ch] = vecs[v].inv;
        end else begin
          c[vecs[v].ch] = vecs[v].pat[k % L];
          t[vecs[v].ch] = (k % L) == 0;
          p[vecs[v].ch] = (k > 2 * L) && (k < 3 * L);
        end
        push(mk(c, t, p), ch_mask(vecs[v].ch));
        cyc();
        check(vecs[v].name);
        if (k == 2 * L) write_cfg(vecs[v].ch, vecs[v].div, vecs[v].high, vecs[v].inv, 1'b0);
      end
    end

    // Sync: ch0 P=5, ch2 P=7 (both disabled now, so applied at once), skew the
    // phase, then sync together with a ch3 write that must take effect at once.
    write_cfg(0, 5, 2, 1'b0, 1'b1);
    cyc();
    write_cfg(2, 7, 3, 1'b0, 1'b1);
    cyc();
    repeat ($urandom_range(3, 20)) cyc();
    sync = 1'b1;
    write_cfg(3, 6, 3, 1'b0, 1'b1);
    for (int k = 0; k <= 70; k++) begin
      logic [CH-1:0] c;
      logic [CH-1:0] t;
      c[0] = (k % 5) < 2;  t[0] = (k % 5) == 0;
      c[1] = (k % 4) == 0; t[1] = (k % 4) == 0;
      c[2] = (k % 7) < 3;  t[2] = (k % 7) == 0;
      c[3] = (k % 6) < 3;  t[3] = (k % 6) == 0;
      push(mk(c, t, '0), '1);
      cyc();
      check("sync_realign");
    end

    // Pending writes on ch0 and ch2, then asynchronous reset mid-period.
    write_cfg(0, 9, 4, 1'b0, 1'b1);
    push(mk('0, '0, 4'b0001), mk('0, '0, 4'b0101));
    cyc();
    check("pend_ch0");
    write_cfg(2, 9, 4, 1'b0, 1'b1);
    push(mk('0, '0, 4'b0101), mk('0, '0, 4'b0101));
    cyc();
    check("pend_ch0_ch2");
    #2;
    rst = 1'b1;
    #1;
    push(mk('0, '1, '0), '1);
    check("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_after_reset(60, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
